// File: rtl/byte_to_word_packer_pkg.sv
// Shared types and sizing helpers for the byte-to-word packer.
// Both the top module and the interface size their buses from these helpers.
package packer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int WORD_CNT_W = 16;

    function automatic int calc_ratio(input int width, input int in_width);
        return width / in_width;
    endfunction

    function automatic int calc_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int calc_lane_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/byte_to_word_packer_if.sv
// Beat input, FIFO write-side and status signals of the packer, grouped into one bundle.
// The master modport is the packer's view; the slave modport is its environment's view.
interface byte_to_word_packer_if
    import packer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 32
);
    localparam int RATIO  = calc_ratio(WIDTH, IN_WIDTH);
    localparam int LANE_W = calc_lane_w(RATIO);

    logic                  in_valid;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_ready;
    logic                  flush;
    logic                  WR_EN;
    logic [WIDTH-1:0]      data_out;
    logic                  full;
    logic [LANE_W-1:0]     out_lanes;
    logic [WORD_CNT_W-1:0] word_count;

    modport master (
        input  in_valid, in_data, flush, full,
        output in_ready, WR_EN, data_out, out_lanes, word_count
    );

    modport slave (
        output in_valid, in_data, flush, full,
        input  in_ready, WR_EN, data_out, out_lanes, word_count
    );

endinterface

// File: rtl/byte_to_word_packer_lane_reg.sv
// Word register with lane writes and a synchronous clear; a lane write on a clear edge lands in the cleared word.
// Byte order: lane 0 in the low bits by default, in the high bits when PACKER_MSB_FIRST_EN is defined.
module packer_lane_reg
    import packer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_clr,
    input  logic                                   i_wr,
    input  logic [calc_idx_w(WIDTH/IN_WIDTH)-1:0]  i_idx,
    input  logic [IN_WIDTH-1:0]                    i_dat,
    output logic [WIDTH-1:0]                       o_word
);
    localparam int RATIO  = calc_ratio(WIDTH, IN_WIDTH);
    localparam int BASE_W = $clog2(WIDTH);

    logic [BASE_W-1:0] w_base;
    logic [WIDTH-1:0]  r_word;

    always_comb begin
`ifdef PACKER_MSB_FIRST_EN
        w_base = BASE_W'((RATIO - 1 - int'(i_idx)) * IN_WIDTH);
`else
        w_base = BASE_W'(int'(i_idx) * IN_WIDTH);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word <= '0;
        end else begin
            if (i_clr) begin
                r_word <= '0;
            end
            if (i_wr) begin
                r_word[w_base +: IN_WIDTH] <= i_dat;
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/byte_to_word_packer.sv
// Packs WIDTH/IN_WIDTH beats into one word and writes it to the FIFO the cycle after it completes; zero-bubble.
// FIFO full holds the pending word and drops in_ready; PACKER_MSB_FIRST_EN selects first-beat-in-MSB lane order.
module byte_to_word_packer
    import packer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    byte_to_word_packer_if.master   bus
);
    localparam int RATIO  = calc_ratio(WIDTH, IN_WIDTH);
    localparam int IDX_W  = calc_idx_w(RATIO);
    localparam int LANE_W = calc_lane_w(RATIO);

    generate
        if (((WIDTH % IN_WIDTH) != 0) || ((WIDTH / IN_WIDTH) < 2)) begin : g_bad_ratio
            $error("byte_to_word_packer: WIDTH must be a multiple of IN_WIDTH with a ratio of at least 2");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [LANE_W-1:0]     r_out_lanes;
    logic [LANE_W-1:0]     w_lanes_nxt;
    logic [WORD_CNT_W-1:0] r_word_count;
    logic [WORD_CNT_W-1:0] w_count_nxt;
    logic                  r_flush_pend;
    logic                  w_fpend_nxt;

    logic                  w_wr_en;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last_lane;
    logic                  w_do_flush;
    logic                  w_clr;
    logic [WIDTH-1:0]      w_word;

    always_comb begin
        w_wr_en     = rst && (r_state == ISSUE) && !bus.full;
        w_in_ready  = rst && ((r_state == FILL) || w_wr_en);
        w_accept    = bus.in_valid && w_in_ready;
        w_last_lane = (r_idx == IDX_W'(RATIO - 1));
        // A pending flush only fires once the new word holds at least one lane.
        w_do_flush  = (bus.flush && ((r_idx != '0) || w_accept))
                   || (r_flush_pend && (r_idx != '0));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_lanes_nxt = r_out_lanes;
        w_count_nxt = r_word_count;
        w_fpend_nxt = r_flush_pend;
        w_clr       = 1'b0;

        case (r_state)
            FILL: begin
                if (w_accept && w_last_lane) begin
                    w_state_nxt = ISSUE;
                    w_idx_nxt   = '0;
                    w_lanes_nxt = LANE_W'(RATIO);
                    w_fpend_nxt = 1'b0;
                end else if (w_do_flush) begin
                    w_state_nxt = ISSUE;
                    w_idx_nxt   = '0;
                    w_lanes_nxt = LANE_W'(r_idx) + LANE_W'(w_accept);
                    w_fpend_nxt = 1'b0;
                end else if (w_accept) begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end

            ISSUE: begin
                if (bus.flush) begin
                    w_fpend_nxt = 1'b1;
                end
                if (w_wr_en) begin
                    w_state_nxt = FILL;
                    w_count_nxt = r_word_count + WORD_CNT_W'(1);
                    w_clr       = 1'b1;
                    w_idx_nxt   = w_accept ? IDX_W'(1) : '0;
                end
            end

            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_out_lanes  <= '0;
            r_word_count <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_out_lanes  <= w_lanes_nxt;
            r_word_count <= w_count_nxt;
            r_flush_pend <= w_fpend_nxt;
        end
    end

    // During ISSUE r_idx is already 0, so a beat taken on the write edge lands in lane 0.
    packer_lane_reg #(
        .IN_WIDTH (IN_WIDTH),
        .WIDTH    (WIDTH)
    ) u_lane_reg (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_wr   (w_accept),
        .i_idx  (r_idx),
        .i_dat  (bus.in_data),
        .o_word (w_word)
    );

    assign bus.WR_EN      = w_wr_en;
    assign bus.in_ready   = w_in_ready;
    assign bus.data_out   = w_word;
    assign bus.out_lanes  = r_out_lanes;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Bench for byte_to_word_packer: directed scenarios plus random traffic against a beat-queue reference model.
module tb_byte_to_word_packer;
    import packer_pkg::*;

    localparam int IN_W  = 8;
    localparam int W     = 32;
    localparam int RATIO = W / IN_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    byte_to_word_packer_if #(.IN_WIDTH(IN_W), .WIDTH(W)) bus();

    byte_to_word_packer #(.IN_WIDTH(IN_W), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: beats collected for the current word, plus one word awaiting a write.
    logic [7:0]  m_beats[$];
    bit          m_pend  = 1'b0;
    logic [31:0] m_word  = '0;
    int          m_lanes = 0;
    bit          m_fpend = 1'b0;
    int          m_wc    = 0;

    logic [31:0] last_wr    = '0;
    logic [31:0] last_lanes = '0;
    int          n_wr       = 0;

    function automatic logic [31:0] pack_beats();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < m_beats.size(); i++) begin
`ifdef PACKER_MSB_FIRST_EN
            w[W - IN_W*(i+1) +: IN_W] = m_beats[i];
`else
            w[IN_W*i +: IN_W] = m_beats[i];
`endif
        end
        return w;
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input bit f, input bit fl, input bit r);
        bit exp_wr;
        bit exp_rdy;
        bit acc;
        int n0;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        bus.full     = fl;
        rst          = r;
        @(negedge clk);
        exp_wr  = r && m_pend && !fl;
        exp_rdy = r && (!m_pend || exp_wr);
        chk("wr_en", 32'(bus.WR_EN), 32'(exp_wr));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("word_count", 32'(bus.word_count), 32'(m_wc));
        if (m_pend) begin
            chk("data_out", bus.data_out, m_word);
            chk("out_lanes", 32'(bus.out_lanes), 32'(m_lanes));
        end
        if (bus.WR_EN === 1'b1) begin
            last_wr    = bus.data_out;
            last_lanes = 32'(bus.out_lanes);
            n_wr++;
        end
        if (!r) begin
            m_beats.delete();
            m_pend  = 1'b0;
            m_fpend = 1'b0;
            m_wc    = 0;
            m_lanes = 0;
            m_word  = '0;
        end else begin
            acc = v && exp_rdy;
            if (m_pend) begin
                if (f) m_fpend = 1'b1;
                if (exp_wr) begin
                    m_pend = 1'b0;
                    m_wc   = (m_wc + 1) % 65536;
                    if (acc) m_beats.push_back(d);
                end
            end else begin
                n0 = m_beats.size();
                if (acc) m_beats.push_back(d);
                if ((m_beats.size() == RATIO) || (f && m_beats.size() > 0) || (m_fpend && n0 > 0)) begin
                    m_word  = pack_beats();
                    m_lanes = m_beats.size();
                    m_pend  = 1'b1;
                    m_fpend = 1'b0;
                    m_beats.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_wr = 0;
    endtask

    initial begin
        logic [7:0] b;
        logic [31:0] e;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        bus.full     = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        #1;

        do_reset();
        chk("rst_out_lanes", 32'(bus.out_lanes), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);

        // Four beats back to back make one full word.
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 * (i + 1));
            step(1'b1, b, 1'b0, 1'b0, 1'b1);
        end
        idle(2);
`ifdef PACKER_MSB_FIRST_EN
        e = 32'h11223344;
`else
        e = 32'h44332211;
`endif
        chk("t1_word", last_wr, e);
        chk("t1_lanes", last_lanes, 32'd4);
        chk("t1_nwr", 32'(n_wr), 32'd1);
        chk("t1_count", 32'(bus.word_count), 32'd1);

        // Continuous stream: two words, no bubbles.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        idle(2);
`ifdef PACKER_MSB_FIRST_EN
        e = 32'h05060708;
`else
        e = 32'h08070605;
`endif
        chk("t2_word", last_wr, e);
        chk("t2_nwr", 32'(n_wr), 32'd2);

        // FIFO full for five cycles after the word completes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 * (i + 1));
            step(1'b1, b, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        chk("t3_hold_nwr", 32'(n_wr), 32'd0);
        idle(2);
        chk("t3_nwr", 32'(n_wr), 32'd1);
        chk("t3_count", 32'(bus.word_count), 32'd1);

        // Flush of a two-lane partial word, then a flush with nothing buffered.
        do_reset();
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
`ifdef PACKER_MSB_FIRST_EN
        e = 32'hAABB0000;
`else
        e = 32'h0000BBAA;
`endif
        chk("t4_word", last_wr, e);
        chk("t4_lanes", last_lanes, 32'd2);
        n_wr = 0;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("t4_empty_flush_nwr", 32'(n_wr), 32'd0);

        // Beat and flush in the same cycle.
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        idle(2);
`ifdef PACKER_MSB_FIRST_EN
        e = 32'hAA000000;
`else
        e = 32'h000000AA;
`endif
        chk("t4b_word", last_wr, e);
        chk("t4b_lanes", last_lanes, 32'd1);

        // Reset in the middle of a word discards the partial beats.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h55 + 8'h11 * i);
            step(1'b1, b, 1'b0, 1'b0, 1'b1);
        end
        idle(2);
`ifdef PACKER_MSB_FIRST_EN
        e = 32'h55667788;
`else
        e = 32'h88776655;
`endif
        chk("t5_word", last_wr, e);
        chk("t5_count", 32'(bus.word_count), 32'd1);

        // Random traffic with flushes, backpressure and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7,
                 8'($urandom),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 199) != 0);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
